// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU-wide types and constants.
//   reg_idx_t      - 4-bit architectural register index
//   word_t         - 32-bit data word
//   REG_SP/LR/PC   - well-known register indices
//   PC_READ_OFFSET - value added to the fetch PC when r15 is read
package cpu_pkg;

    typedef logic [3:0]  reg_idx_t;
    typedef logic [31:0] word_t;

    localparam reg_idx_t REG_SP = 4'd13;
    localparam reg_idx_t REG_LR = 4'd14;
    localparam reg_idx_t REG_PC = 4'd15;

    localparam int PC_READ_OFFSET = 8;

endpackage : cpu_pkg

// File: rtl/regfile_read_port.sv
// regfile_read_port: one registered read port of the register file.
// Selects a stored entry by address, substitutes pc_in + PC_OFFSET for r15,
// optionally forwards a same-edge write, and registers the result.
// Optional feature macro: REGFILE_BYPASS_EN (same-edge write forwarding).
// Ports:
//   clk, reset      - clock, asynchronous active-low reset
//   rd_en           - capture a new value this edge
//   addr            - register index to read
//   entries         - packed view of stored registers r0..r(NUM_REGS-2)
//   pc_in           - fetch PC, sampled at the read edge
//   we/wr_addr/wr_data - write port, used only for forwarding
//   data            - registered read result (holds when rd_en=0)
module regfile_read_port
    import cpu_pkg::*;
#(
    parameter int NUM_REGS  = 16,
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 4,
    parameter int PC_OFFSET = PC_READ_OFFSET
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 rd_en,
    input  logic [ADDR_W-1:0]                    addr,
    input  logic [NUM_REGS-2:0][DATA_W-1:0]      entries,
    input  logic [DATA_W-1:0]                    pc_in,
    input  logic                                 we,
    input  logic [ADDR_W-1:0]                    wr_addr,
    input  logic [DATA_W-1:0]                    wr_data,
    output logic [DATA_W-1:0]                    data
);

    logic [DATA_W-1:0] data_reg;
    logic [DATA_W-1:0] data_next;
    logic              is_pc;

    assign is_pc = (addr == ADDR_W'(REG_PC));

    always_comb begin
        data_next = '0;
        for (int i = 0; i < NUM_REGS - 1; i++) begin
            if (addr == ADDR_W'(i)) begin
                data_next = entries[i];
            end
        end
        // r15 has no storage; the PC view wraps silently at 2^DATA_W.
        if (is_pc) begin
            data_next = pc_in + DATA_W'(PC_OFFSET);
        end
`ifdef REGFILE_BYPASS_EN
        // Forward the write landing on this same edge so decode need not stall.
        if (we && (wr_addr == addr) && !is_pc) begin
            data_next = wr_data;
        end
`endif
    end

`ifndef REGFILE_BYPASS_EN
    // Write port is only needed for forwarding; tie it off in this build.
    logic unused_wr;
    assign unused_wr = ^{we, wr_addr, wr_data};
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_reg <= '0;
        end else if (rd_en) begin
            data_reg <= data_next;
        end
    end

    assign data = data_reg;

endmodule : regfile_read_port

// File: rtl/register_file.sv
// register_file: 16-entry ARM general-purpose register file, one write
// port, two registered read ports (A, B). r15 is not stored; reads of r15
// return pc_in + PC_OFFSET.
// Optional feature macro: REGFILE_BYPASS_EN (same-edge write->read forwarding).
// Ports:
//   clk, reset          - clock, asynchronous active-low reset
//   rd_en               - read request for both ports
//   ra_addr, rb_addr    - operand A/B register indices
//   ra_data, rb_data    - registered operand values (one-cycle latency)
//   rd_valid            - one-cycle pulse per captured read
//   we, wr_addr, wr_data - writeback port (writes to r15 are dropped)
//   pc_in               - current fetch PC
module register_file
    import cpu_pkg::*;
#(
    parameter int NUM_REGS  = 16,
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 4,
    parameter int PC_OFFSET = PC_READ_OFFSET
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] ra_addr,
    input  logic [ADDR_W-1:0] rb_addr,
    output logic [DATA_W-1:0] ra_data,
    output logic [DATA_W-1:0] rb_data,
    output logic              rd_valid,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [DATA_W-1:0] pc_in
);

    // Entries r0..r14 only; the top index (r15) is never matched below,
    // which is what drops writes to the PC.
    logic [NUM_REGS-2:0][DATA_W-1:0] entry_reg;
    logic                            rd_valid_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS - 1; gi++) begin : g_entry
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    entry_reg[gi] <= '0;
                end else if (we && (wr_addr == ADDR_W'(gi))) begin
                    entry_reg[gi] <= wr_data;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_valid_reg <= 1'b0;
        end else begin
            rd_valid_reg <= rd_en;
        end
    end

    assign rd_valid = rd_valid_reg;

    regfile_read_port #(
        .NUM_REGS (NUM_REGS),
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .PC_OFFSET(PC_OFFSET)
    ) u_port_a (
        .clk     (clk),
        .reset   (reset),
        .rd_en   (rd_en),
        .addr    (ra_addr),
        .entries (entry_reg),
        .pc_in   (pc_in),
        .we      (we),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .data    (ra_data)
    );

    regfile_read_port #(
        .NUM_REGS (NUM_REGS),
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .PC_OFFSET(PC_OFFSET)
    ) u_port_b (
        .clk     (clk),
        .reset   (reset),
        .rd_en   (rd_en),
        .addr    (rb_addr),
        .entries (entry_reg),
        .pc_in   (pc_in),
        .we      (we),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .data    (rb_data)
    );

endmodule : register_file

// File: tb/tb_register_file.sv
// tb_register_file: scoreboard bench for register_file. Stimulus pushes the
// hand-computed {ra,rb} expectation for every read it issues; a monitor on
// the falling edge pops and compares whenever rd_valid is high.
module tb_register_file;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rd_en = 1'b0;
    logic [3:0]  ra_addr = '0;
    logic [3:0]  rb_addr = '0;
    logic [31:0] ra_data;
    logic [31:0] rb_data;
    logic        rd_valid;
    logic        we = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic [31:0] pc_in = '0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] exp_q[$];

    register_file dut (
        .clk     (clk),
        .reset   (reset),
        .rd_en   (rd_en),
        .ra_addr (ra_addr),
        .rb_addr (rb_addr),
        .ra_data (ra_data),
        .rb_data (rb_data),
        .rd_valid(rd_valid),
        .we      (we),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .pc_in   (pc_in)
    );

    always #5 clk = ~clk;

`ifdef REGFILE_BYPASS_EN
    localparam logic [31:0] COLLIDE_EXP = 32'h22;
`else
    localparam logic [31:0] COLLIDE_EXP = 32'h11;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    // One cycle of stimulus; inputs change 1 time unit after the rising edge.
    task automatic cyc(input logic r, input logic [3:0] a, input logic [3:0] b,
                       input logic w, input logic [3:0] wa, input logic [31:0] wd,
                       input logic [31:0] pc, input logic [31:0] ea, input logic [31:0] eb);
        rd_en = r; ra_addr = a; rb_addr = b;
        we = w; wr_addr = wa; wr_data = wd; pc_in = pc;
        if (r) exp_q.push_back({ea, eb});
        @(posedge clk);
        #1;
        rd_en = 1'b0; we = 1'b0;
    endtask

    // Monitor: every valid read must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (reset && rd_valid) begin
            logic [63:0] e;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_rd_valid: got ra=%h rb=%h expected no read", ra_data, rb_data);
            end else begin
                e = exp_q.pop_front();
                check("read_ra", ra_data, e[63:32]);
                check("read_rb", rb_data, e[31:0]);
            end
        end
    end

    initial begin
        // Asynchronous reset before any clock edge.
        #2 reset = 1'b0;
        #1;
        check("rst_ra_data", ra_data, 32'h0);
        check("rst_rb_data", rb_data, 32'h0);
        check("rst_rd_valid", {31'b0, rd_valid}, 32'h0);
        reset = 1'b1;
        @(posedge clk); #1;

        // All stored registers read back zero after reset.
        for (int i = 0; i < 15; i++) begin
            cyc(1'b1, 4'(i), 4'(14 - i), 1'b0, 4'd0, 32'h0, 32'h0, 32'h0, 32'h0);
        end

        // Write then read r3 on both ports.
        cyc(1'b0, 4'd0, 4'd0, 1'b1, 4'd3, 32'hDEADBEEF, 32'h0, 32'h0, 32'h0);
        cyc(1'b1, 4'd3, 4'd3, 1'b0, 4'd0, 32'h0, 32'h0, 32'hDEADBEEF, 32'hDEADBEEF);
        cyc(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 32'h0, 32'h0, 32'h0, 32'h0);
        check("valid_single_pulse", {31'b0, rd_valid}, 32'h0);

        // r15 reads return pc_in + 8 with wrap; writes to r15 are dropped.
        cyc(1'b1, 4'd15, 4'd0, 1'b0, 4'd0, 32'h0, 32'h00001000, 32'h00001008, 32'h0);
        cyc(1'b1, 4'd15, 4'd15, 1'b0, 4'd0, 32'h0, 32'hFFFFFFFC, 32'h00000004, 32'h00000004);
        cyc(1'b0, 4'd0, 4'd0, 1'b1, 4'd15, 32'h00001234, 32'h0, 32'h0, 32'h0);
        cyc(1'b1, 4'd15, 4'd3, 1'b0, 4'd0, 32'h0, 32'h00002000, 32'h00002008, 32'hDEADBEEF);

        // Same-edge read/write collision on r5.
        cyc(1'b0, 4'd0, 4'd0, 1'b1, 4'd5, 32'h11, 32'h0, 32'h0, 32'h0);
        cyc(1'b1, 4'd5, 4'd3, 1'b1, 4'd5, 32'h22, 32'h0, COLLIDE_EXP, 32'hDEADBEEF);
        cyc(1'b1, 4'd5, 4'd5, 1'b0, 4'd0, 32'h0, 32'h0, 32'h22, 32'h22);

        // Hold: outputs keep the last read while rd_en is low.
        cyc(1'b0, 4'd0, 4'd0, 1'b1, 4'd1, 32'hA5A5A5A5, 32'h0, 32'h0, 32'h0);
        cyc(1'b1, 4'd1, 4'd1, 1'b0, 4'd0, 32'h0, 32'h0, 32'hA5A5A5A5, 32'hA5A5A5A5);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 4'd2, 4'd2, 1'b1, 4'd1, 32'h0, 32'h0, 32'h0, 32'h0);
            check("hold_ra_data", ra_data, 32'hA5A5A5A5);
            check("hold_rd_valid", {31'b0, rd_valid}, 32'h0);
        end
        cyc(1'b1, 4'd1, 4'd3, 1'b0, 4'd0, 32'h0, 32'h0, 32'h0, 32'hDEADBEEF);

        // Streaming reads: rd_valid stays high, data in order.
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 4'd0, 4'd0, 1'b1, 4'(i), 32'(10 + i), 32'h0, 32'h0, 32'h0);
        end
        for (int i = 0; i < 4; i++) begin
            rd_en = 1'b1; ra_addr = 4'(i); rb_addr = 4'(3 - i);
            exp_q.push_back({32'(10 + i), 32'(13 - i)});
            @(posedge clk); #1;
            check("stream_rd_valid", {31'b0, rd_valid}, 32'h1);
        end
        rd_en = 1'b0;
        @(posedge clk); #1;

        // Streaming interrupted by reset on the third read.
        for (int i = 0; i < 2; i++) begin
            rd_en = 1'b1; ra_addr = 4'(i); rb_addr = 4'(i);
            exp_q.push_back({32'(10 + i), 32'(10 + i)});
            @(posedge clk); #1;
        end
        rd_en = 1'b1; ra_addr = 4'd2; rb_addr = 4'd2;
        @(posedge clk); #1;
        reset = 1'b0;   // in-flight read of r2 is discarded
        #1;
        check("midrst_ra_data", ra_data, 32'h0);
        check("midrst_rb_data", rb_data, 32'h0);
        check("midrst_rd_valid", {31'b0, rd_valid}, 32'h0);
        rd_en = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check("post_rst_rd_valid", {31'b0, rd_valid}, 32'h0);
        cyc(1'b1, 4'd2, 4'd3, 1'b0, 4'd0, 32'h0, 32'h0, 32'h0, 32'h0);

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        check("scoreboard_empty", 32'(exp_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_register_file
